time_ascii_sender: RTL

Consumes the registered 32-bit BCD time snapshot produced by the FND display controller, which is packed as {h10,h1,m10,m1,s10,s1,ms10,ms1}. On a manual or periodic trigger it formats the snapshot as the ASCII frame "HH:MM:SS.CC\r\n" and streams it one byte at a time over a valid/ready handshake to the UART TX stage. It sits between the FND controller and the UART transmitter.

---
 rtl/time_ascii_sender_pkg.sv | 48 ++++
 rtl/time_ascii_sender_send_trigger.sv | 55 +++++
 rtl/time_ascii_sender.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/time_ascii_sender_pkg.sv
// ----------------------------------------------------------------------------
// time_ascii_sender_pkg
//
// Purpose:
//   Shared definitions for the time-to-ASCII frame sender: ASCII code points
//   used in the "HH:MM:SS.CC\r\n" frame, the FSM state encoding, and small
//   helper functions for frame length and BCD digit encoding.
//
// Contents:
//   ASCII_*        byte constants used by the frame mux
//   state_t        FSM states IDLE / SEND / DONE
//   frame_len()    13 with CR LF terminator, 11 without
//   digit_ascii()  BCD digit -> ASCII, non-decimal nibbles -> '?'
// ----------------------------------------------------------------------------
package time_ascii_sender_pkg;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of bytes in one frame; the index register is sized for 13.
   function automatic logic [3:0] frame_len(input logic add_crlf);
      return add_crlf ? 4'd13 : 4'd11;
   endfunction

   // A nibble of 10..15 is not a decimal digit; it is shown as '?' so a
   // corrupted snapshot is visible on the terminal instead of printing
   // punctuation characters.
   function automatic logic [7:0] digit_ascii(input logic [3:0] d);
      logic [7:0] c;
      if (d <= 4'd9) begin
         c = ASCII_0 + {4'h0, d};
      end else begin
         c = ASCII_QMARK;
      end
      return c;
   endfunction

endpackage

// File: rtl/time_ascii_sender_send_trigger.sv
// ----------------------------------------------------------------------------
// send_trigger
//
// Purpose:
//   Produces the frame request for the time sender. A request is either the
//   manual i_send level or a one-cycle tick from a free-running period
//   counter that runs only while i_auto_en is high. Both sources are merged
//   into a single request, so a manual send landing on the tick cycle still
//   counts as one request.
//
// Parameters:
//   AUTO_PERIOD  clk cycles between automatic ticks (minimum 2)
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   i_send     in   manual send request (level)
//   i_auto_en  in   enables the period counter; low holds it at 0
//   o_req      out  merged request, combinational from i_send and the tick
// ----------------------------------------------------------------------------
module send_trigger #(
   parameter int AUTO_PERIOD = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_send,
   input  logic i_auto_en,
   output logic o_req
);

   localparam int CNT_W = $clog2(AUTO_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_PERIOD - 1);

   logic [CNT_W-1:0] auto_cnt;
   logic             auto_tick;

   // The tick fires on the cycle the counter sits at its last value, so with
   // the enable held high one tick occurs every AUTO_PERIOD cycles and the
   // first one comes AUTO_PERIOD cycles after the enable rises.
   assign auto_tick = i_auto_en && (auto_cnt == CNT_LAST);
   assign o_req     = i_send || auto_tick;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         auto_cnt <= '0;
      end else if (!i_auto_en) begin
         auto_cnt <= '0;
      end else if (auto_cnt == CNT_LAST) begin
         auto_cnt <= '0;
      end else begin
         auto_cnt <= auto_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/time_ascii_sender.sv
// ----------------------------------------------------------------------------
// time_ascii_sender
//
// Purpose:
//   Formats the packed BCD time snapshot {h10,h1,m10,m1,s10,s1,ms10,ms1}
//   from the FND controller as "HH:MM:SS.CC" (optionally followed by CR LF)
//   and streams it one byte at a time to the UART transmitter.
//
// Handshake:
//   A byte transfers on every rising clk edge where o_tx_valid and
//   i_tx_ready are both high. Once o_tx_valid is raised, o_tx_data and
//   o_tx_valid stay unchanged until that transfer happens; i_tx_ready may
//   toggle freely and never causes a byte to be skipped or repeated.
//
// Parameters:
//   AUTO_PERIOD  clk cycles between automatic sends while i_auto_en = 1
//   ADD_CRLF     1 = 13-byte frame with CR LF, 0 = 11-byte frame
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   i_time_bcd  in   32-bit packed BCD time
//   i_send      in   manual send request (level)
//   i_auto_en   in   enables periodic sends
//   o_tx_data   out  current ASCII byte
//   o_tx_valid  out  o_tx_data holds a byte to transfer
//   i_tx_ready  in   UART TX can accept a byte
//   o_busy      out  a frame is in progress (SEND or DONE)
//   o_done      out  one-cycle pulse after the last byte is accepted
// ----------------------------------------------------------------------------
module time_ascii_sender
   import time_ascii_sender_pkg::*;
#(
   parameter int AUTO_PERIOD = 100_000_000,
   parameter int ADD_CRLF    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_time_bcd,
   input  logic        i_send,
   input  logic        i_auto_en,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [3:0] LAST_IDX = frame_len(ADD_CRLF != 0) - 4'd1;

   state_t      state;
   logic [3:0]  idx;
   logic [31:0] snap;
   logic        pending;
   logic        req;
   logic        handshake;

   send_trigger #(
      .AUTO_PERIOD (AUTO_PERIOD)
   ) u_trig (
      .clk       (clk),
      .reset     (reset),
      .i_send    (i_send),
      .i_auto_en (i_auto_en),
      .o_req     (req)
   );

   assign handshake = o_tx_valid && i_tx_ready;

   // Byte at position idx of the frame built from snapshot t. Positions 11
   // and 12 are only ever reached when the CR LF terminator is enabled.
   function automatic logic [7:0] frame_byte(input logic [31:0] t,
                                             input logic [3:0]  i);
      logic [7:0] b;
      case (i)
         4'd0:    b = digit_ascii(t[31:28]);
         4'd1:    b = digit_ascii(t[27:24]);
         4'd2:    b = ASCII_COLON;
         4'd3:    b = digit_ascii(t[23:20]);
         4'd4:    b = digit_ascii(t[19:16]);
         4'd5:    b = ASCII_COLON;
         4'd6:    b = digit_ascii(t[15:12]);
         4'd7:    b = digit_ascii(t[11:8]);
         4'd8:    b = ASCII_DOT;
         4'd9:    b = digit_ascii(t[7:4]);
         4'd10:   b = digit_ascii(t[3:0]);
         4'd11:   b = ASCII_CR;
         4'd12:   b = ASCII_LF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Outputs are registered: the byte for the next index is computed from the
   // frozen snapshot at the same edge that advances the index, so o_tx_data
   // never depends combinationally on i_time_bcd or i_tx_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= 4'd0;
         snap       <= 32'h0;
         pending    <= 1'b0;
         o_tx_data  <= 8'h00;
         o_tx_valid <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  snap       <= i_time_bcd;
                  idx        <= 4'd0;
                  o_tx_data  <= frame_byte(i_time_bcd, 4'd0);
                  o_tx_valid <= 1'b1;
                  o_busy     <= 1'b1;
                  state      <= SEND;
               end
            end

            SEND: begin
               // One-deep pending: any number of requests during a frame
               // collapse into a single follow-up frame.
               if (req) begin
                  pending <= 1'b1;
               end
               if (handshake) begin
                  if (idx == LAST_IDX) begin
                     o_tx_valid <= 1'b0;
                     o_done     <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx       <= idx + 4'd1;
                     o_tx_data <= frame_byte(snap, idx + 4'd1);
                  end
               end
            end

            DONE: begin
               // A request arriving on this very cycle is served here as
               // well; otherwise it would be marked pending with nothing
               // left in IDLE to consume it.
               if (pending || req) begin
                  pending    <= 1'b0;
                  snap       <= i_time_bcd;
                  idx        <= 4'd0;
                  o_tx_data  <= frame_byte(i_time_bcd, 4'd0);
                  o_tx_valid <= 1'b1;
                  state      <= SEND;
               end else begin
                  idx    <= 4'd0;
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end
            end

            default: begin
               idx        <= 4'd0;
               pending    <= 1'b0;
               o_tx_valid <= 1'b0;
               o_busy     <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
